rtc_display_scheduler: RTL



---
 rtl/rtc_disp_pkg.sv | 34 +++
 rtl/rtc_display_scheduler_blink_gen.sv | 43 ++++
 rtl/rtc_display_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/rtc_disp_pkg.sv
// Shared constants and helpers for the RTC display scheduler.
package rtc_disp_pkg;

  localparam int unsigned N_DIGITS   = 18;
  localparam int unsigned DATE_BASE  = 0;
  localparam int unsigned TIME_BASE  = 6;
  localparam int unsigned TIMER_BASE = 12;
  localparam int unsigned V_ACTIVE   = 480;

  // Edit-field selector: each non-zero value picks the digit pair (2k-2, 2k-1).
  typedef enum logic [3:0] {
    FLD_NONE = 4'd0,
    FLD_DD   = 4'd1,
    FLD_MO   = 4'd2,
    FLD_YY   = 4'd3,
    FLD_HH   = 4'd4,
    FLD_MI   = 4'd5,
    FLD_SS   = 4'd6,
    FLD_THR  = 4'd7,
    FLD_TMIN = 4'd8,
    FLD_TSEC = 4'd9
  } edit_field_e;

  // Slots belonging to the selected edit field; out-of-range selectors give no slots.
  function automatic logic [N_DIGITS-1:0] field_mask(input logic [3:0] fld);
    logic [N_DIGITS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      m[i] = (fld != FLD_NONE) && (fld <= FLD_TSEC) && (4'(i / 2 + 1) == fld);
    end
    return m;
  endfunction

endpackage

// File: rtl/rtc_display_scheduler_blink_gen.sv
// Blink phase generator: toggles the phase every BLINK_FRAMES frame ticks.
module blink_gen #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic CLK,
  input  logic RESET,
  input  logic frame_tick,
  output logic blink_phase
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Next-state: count frame ticks, wrap and toggle the phase at the end of a half-period.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_tick) begin
      if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter and phase registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/rtc_display_scheduler.sv
// Frame-synchronous digit scheduler: shadow bank written over req/ack,
// committed to the display bank at vblank start, plus blink mask output.
module rtc_display_scheduler
  import rtc_disp_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [9:0]            pix_y,
  input  logic                  wr_req,
  input  logic [4:0]            wr_addr,
  input  logic [3:0]            wr_data,
  output logic                  wr_ack,
  output logic                  wr_err,
  input  logic [3:0]            edit_field,
  output logic [4*N_DIGITS-1:0] disp_digits,
  output logic [N_DIGITS-1:0]   disp_blank,
  output logic                  frame_tick
);

  logic                vb;
  logic                vb_q;
  logic                tick_q;
  logic                ack_q, err_q;
  logic                dirty_q, dirty_d;
  logic                accept, wr_bad, commit;
  logic                blink_phase;
  logic [3:0]          shadow_q  [N_DIGITS];
  logic [3:0]          display_q [N_DIGITS];
  logic [N_DIGITS-1:0] blank_q;

  assign vb     = (pix_y >= 10'(V_ACTIVE));
  // Commit owns the tick cycle; a pending request waits one cycle and lands in the next frame.
  assign accept = wr_req & ~ack_q & ~tick_q;
  assign wr_bad = (wr_addr >= 5'(N_DIGITS)) | (wr_data > 4'd9);
  assign commit = tick_q & dirty_q;

  // Vblank edge detect; vb_q resets high so no tick fires straight out of reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vb_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      vb_q   <= vb;
      tick_q <= vb & ~vb_q;
    end
  end

  // Write handshake: one-cycle ack, with err for dropped writes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= accept;
      err_q <= accept & wr_bad;
    end
  end

  // Dirty flag: set by a valid write, cleared by a commit (never in the same cycle).
  always_comb begin
    dirty_d = dirty_q;
    if (commit)             dirty_d = 1'b0;
    else if (accept && !wr_bad) dirty_d = 1'b1;
  end

  // Shadow and display banks.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
        shadow_q[i]  <= '0;
        display_q[i] <= '0;
      end
      dirty_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
        if (accept && !wr_bad && (wr_addr == 5'(i))) shadow_q[i] <= wr_data;
        if (commit) display_q[i] <= shadow_q[i];
      end
      dirty_q <= dirty_d;
    end
  end

  blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .CLK        (CLK),
    .RESET      (RESET),
    .frame_tick (tick_q),
    .blink_phase(blink_phase)
  );

  // Registered blank mask for the field under edit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) blank_q <= '0;
    else       blank_q <= blink_phase ? field_mask(edit_field) : '0;
  end

  // Flatten the display bank onto the output bus.
  always_comb begin
    disp_digits = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      disp_digits[4*i +: 4] = display_q[i];
    end
  end

  assign wr_ack     = ack_q;
  assign wr_err     = err_q;
  assign frame_tick = tick_q;
  assign disp_blank = blank_q;

endmodule
